// File: rtl/spi_rr_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_rr_master
// Purpose  : SPI mode-0 master shared by two clients through a round-robin
//            arbiter. One full-duplex LSB-first word per grant.
// Revision : 1.0 - initial release
// ============================================================================
module spi_rr_master #(
  parameter int REG_WIDTH = 8,
  parameter int CLK_DIV   = 4,
  parameter int CS_GAP    = 2
) (
  input  logic                 sys_clk,
  input  logic                 rstn,
  input  logic [1:0]           req,
  input  logic [REG_WIDTH-1:0] tx_data0,
  input  logic [REG_WIDTH-1:0] tx_data1,
  output logic [1:0]           gnt,
  output logic [1:0]           done,
  output logic [REG_WIDTH-1:0] rx_data,
  output logic                 busy,
  output logic                 cs,
  output logic                 sclk,
  output logic                 mosi,
  input  logic                 miso
);

  // One counter times both the sclk half-periods and the inter-transaction gap.
  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int EDGE_W  = $clog2(2 * REG_WIDTH);

  localparam logic [CNT_W-1:0]  c_div_last  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  c_gap_last  = CNT_W'((CS_GAP > 0) ? (CS_GAP - 1) : 0);
  localparam logic [EDGE_W-1:0] c_edge_last = EDGE_W'(2 * REG_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [EDGE_W-1:0]     r_edge;
  logic [REG_WIDTH-1:0]  r_tx;
  logic [REG_WIDTH-1:0]  r_rx;
  logic                  r_last;
  logic                  w_win;
  logic                  w_cnt_done;

  // Counter expiry: gap length in GAP, half-period length everywhere else.
  assign w_cnt_done = (r_state == S_GAP) ? (r_cnt == c_gap_last) : (r_cnt == c_div_last);

  // Round-robin winner: a lone requester wins; on a tie the client not granted last wins.
  always_comb begin
    w_win = 1'b0;
    case (req)
      2'b10:   w_win = 1'b1;
      2'b11:   w_win = ~r_last;
      default: w_win = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (|req) w_next = S_SETUP;
      S_SETUP: if (w_cnt_done) w_next = S_SHIFT;
      S_SHIFT: if (w_cnt_done && sclk && (r_edge == c_edge_last)) w_next = S_HOLD;
      S_HOLD:  if (w_cnt_done) w_next = (CS_GAP == 0) ? S_IDLE : S_GAP;
      S_GAP:   if (w_cnt_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: grant capture, sclk generation, shift registers and bus outputs.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt   <= '0;
      r_edge  <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_last  <= 1'b1;
      gnt     <= 2'b00;
      done    <= 2'b00;
      rx_data <= '0;
      busy    <= 1'b0;
      cs      <= 1'b1;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
    end else begin
      done <= 2'b00;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (|req) begin
            gnt    <= w_win ? 2'b10 : 2'b01;
            r_last <= w_win;
            busy   <= 1'b1;
            cs     <= 1'b0;
            r_tx   <= w_win ? tx_data1 : tx_data0;
            mosi   <= w_win ? tx_data1[0] : tx_data0[0];
            r_edge <= '0;
            r_rx   <= '0;
          end
        end
        S_SETUP: begin
          r_cnt <= w_cnt_done ? '0 : r_cnt + 1'b1;
        end
        S_SHIFT: begin
          r_cnt <= w_cnt_done ? '0 : r_cnt + 1'b1;
          if (w_cnt_done) begin
            sclk   <= ~sclk;
            r_edge <= r_edge + 1'b1;
            if (!sclk) begin
              // Rising edge: capture miso, first bit ends up in the LSB.
              r_rx <= {miso, r_rx[REG_WIDTH-1:1]};
            end else if (r_edge != c_edge_last) begin
              // Falling edge: present the next tx bit; after the last fall mosi holds.
              r_tx <= r_tx >> 1;
              mosi <= r_tx[1];
            end
          end
        end
        S_HOLD: begin
          r_cnt <= w_cnt_done ? '0 : r_cnt + 1'b1;
          if (w_cnt_done) begin
            cs      <= 1'b1;
            gnt     <= 2'b00;
            done    <= gnt;
            rx_data <= r_rx;
            if (CS_GAP == 0) busy <= 1'b0;
          end
        end
        S_GAP: begin
          r_cnt <= w_cnt_done ? '0 : r_cnt + 1'b1;
          if (w_cnt_done) busy <= 1'b0;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_rr_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_rr_master
// Purpose  : Directed self-checking bench for spi_rr_master (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_rr_master;

  logic       sys_clk = 1'b0;
  logic       rstn;
  logic [1:0] req;
  logic [7:0] tx_data0;
  logic [7:0] tx_data1;
  logic [1:0] gnt;
  logic [1:0] done;
  logic [7:0] rx_data;
  logic       busy;
  logic       cs;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       miso_drv;
  logic       loop_en;

  int total = 0;
  int bad   = 0;

  assign miso = loop_en ? mosi : miso_drv;

  always #5 sys_clk = ~sys_clk;

  spi_rr_master #(.REG_WIDTH(8), .CLK_DIV(4), .CS_GAP(2)) dut (
    .sys_clk  (sys_clk),
    .rstn     (rstn),
    .req      (req),
    .tx_data0 (tx_data0),
    .tx_data1 (tx_data1),
    .gnt      (gnt),
    .done     (done),
    .rx_data  (rx_data),
    .busy     (busy),
    .cs       (cs),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso)
  );

  // Follow one transaction from the current negedge: wait for cs low, then
  // observe until cs rises; the sample at the cs-rise negedge holds done/rx_data.
  task automatic watch(input logic [7:0] pat,
                       output int wait_cyc, output int idle_cyc, output int low_cyc,
                       output int rises, output logic [7:0] mosi_bits,
                       output logic [1:0] gnt_seen, output logic [1:0] done_seen,
                       output logic [7:0] rx_seen, output logic gnt_bad, output logic ok);
    logic prev;
    int   guard;
    wait_cyc = 0; idle_cyc = 0; low_cyc = 0; rises = 0;
    mosi_bits = 8'h00; gnt_seen = 2'b00; done_seen = 2'b00; rx_seen = 8'h00;
    gnt_bad = 1'b0; ok = 1'b1;
    miso_drv = pat[0];
    guard = 0;
    while (cs !== 1'b0 && guard < 300) begin
      wait_cyc++;
      if (busy === 1'b0) idle_cyc++;
      guard++;
      @(negedge sys_clk);
    end
    if (cs !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    gnt_seen = gnt;
    prev = 1'b0;
    guard = 0;
    while (cs === 1'b0 && guard < 300) begin
      low_cyc++;
      if (gnt === 2'b11) gnt_bad = 1'b1;
      if (sclk === 1'b1 && prev === 1'b0) begin
        if (rises < 8) mosi_bits[rises] = mosi;
        rises++;
        if (rises < 8) miso_drv = pat[rises];
      end
      prev = sclk;
      guard++;
      @(negedge sys_clk);
    end
    if (cs !== 1'b1) begin
      ok = 1'b0;
      return;
    end
    done_seen = done;
    rx_seen   = rx_data;
  endtask

  task automatic test_reset();
    rstn = 1'b0; req = 2'b00; tx_data0 = 8'h00; tx_data1 = 8'h00;
    miso_drv = 1'b0; loop_en = 1'b1;
    repeat (3) @(negedge sys_clk);
    total++; if (cs !== 1'b1)       begin bad++; $display("FAIL reset_cs got=%b want=1", cs); end
    total++; if (sclk !== 1'b0)     begin bad++; $display("FAIL reset_sclk got=%b want=0", sclk); end
    total++; if (mosi !== 1'b0)     begin bad++; $display("FAIL reset_mosi got=%b want=0", mosi); end
    total++; if (gnt !== 2'b00)     begin bad++; $display("FAIL reset_gnt got=%b want=00", gnt); end
    total++; if (done !== 2'b00)    begin bad++; $display("FAIL reset_done got=%b want=00", done); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx got=%h want=00", rx_data); end
    rstn = 1'b1;
    repeat (3) @(negedge sys_clk);
    total++; if (cs !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL idle_no_req cs=%b busy=%b want cs=1 busy=0", cs, busy); end
  endtask

  task automatic test_loopback();
    int wc, ic, lc, rs; logic [7:0] mb, rx; logic [1:0] gs, ds; logic gb, ok;
    loop_en = 1'b1; tx_data0 = 8'hA5; req = 2'b01;
    @(negedge sys_clk);
    total++; if (gnt !== 2'b01 || busy !== 1'b1 || cs !== 1'b0)
      begin bad++; $display("FAIL lb_grant_latency gnt=%b busy=%b cs=%b want 01/1/0", gnt, busy, cs); end
    tx_data0 = 8'hFF;
    watch(8'h00, wc, ic, lc, rs, mb, gs, ds, rx, gb, ok);
    total++; if (!ok)          begin bad++; $display("FAIL lb_timeout got=%0d want=1", ok); end
    total++; if (lc !== 72)    begin bad++; $display("FAIL lb_cs_low got=%0d want=72", lc); end
    total++; if (rs !== 8)     begin bad++; $display("FAIL lb_rises got=%0d want=8", rs); end
    total++; if (mb !== 8'hA5) begin bad++; $display("FAIL lb_mosi_bits got=%h want=a5", mb); end
    total++; if (ds !== 2'b01) begin bad++; $display("FAIL lb_done got=%b want=01", ds); end
    total++; if (rx !== 8'hA5) begin bad++; $display("FAIL lb_rx got=%h want=a5", rx); end
    req = 2'b00;
    @(negedge sys_clk);
    total++; if (done !== 2'b00)    begin bad++; $display("FAIL lb_done_width got=%b want=00", done); end
    total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL lb_rx_hold got=%h want=a5", rx_data); end
    repeat (4) @(negedge sys_clk);
    total++; if (busy !== 1'b0 || cs !== 1'b1) begin bad++; $display("FAIL lb_back_idle busy=%b cs=%b want 0/1", busy, cs); end
  endtask

  task automatic test_both_from_reset();
    int wc, ic, lc, rs; logic [7:0] mb, rx; logic [1:0] gs, ds; logic gb, ok;
    loop_en = 1'b1; tx_data0 = 8'h3C; tx_data1 = 8'hC3; req = 2'b11;
    rstn = 1'b0;
    repeat (2) @(negedge sys_clk);
    rstn = 1'b1;
    watch(8'h00, wc, ic, lc, rs, mb, gs, ds, rx, gb, ok);
    total++; if (!ok || gs !== 2'b01 || ds !== 2'b01 || rx !== 8'h3C)
      begin bad++; $display("FAIL both_first ok=%0d gnt=%b done=%b rx=%h want 1/01/01/3c", ok, gs, ds, rx); end
    watch(8'h00, wc, ic, lc, rs, mb, gs, ds, rx, gb, ok);
    total++; if (!ok || gs !== 2'b10 || ds !== 2'b10 || rx !== 8'hC3)
      begin bad++; $display("FAIL both_second ok=%0d gnt=%b done=%b rx=%h want 1/10/10/c3", ok, gs, ds, rx); end
    total++; if (wc < 2) begin bad++; $display("FAIL both_gap got=%0d want>=2", wc); end
    req = 2'b00;
    repeat (5) @(negedge sys_clk);
  endtask

  task automatic test_round_robin();
    int wc, ic, lc, rs; logic [7:0] mb, rx; logic [1:0] gs, ds; logic gb, ok;
    logic [1:0] order [4];
    order[0] = 2'b01; order[1] = 2'b10; order[2] = 2'b01; order[3] = 2'b10;
    loop_en = 1'b1; tx_data0 = 8'h11; tx_data1 = 8'h22; req = 2'b11;
    rstn = 1'b0;
    repeat (2) @(negedge sys_clk);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      watch(8'h00, wc, ic, lc, rs, mb, gs, ds, rx, gb, ok);
      total++; if (!ok || gs !== order[i] || ds !== order[i])
        begin bad++; $display("FAIL rr_order[%0d] ok=%0d gnt=%b done=%b want=%b", i, ok, gs, ds, order[i]); end
      total++; if (gb) begin bad++; $display("FAIL rr_gnt_11[%0d] got=11 want=onehot", i); end
      if (i > 0) begin
        total++; if (ic !== 1) begin bad++; $display("FAIL rr_busy_low[%0d] got=%0d want=1", i, ic); end
      end
    end
    req = 2'b00;
    repeat (5) @(negedge sys_clk);
  endtask

  task automatic test_back_to_back();
    int wc, ic, lc, rs; logic [7:0] mb, rx; logic [1:0] gs, ds; logic gb, ok;
    loop_en = 1'b1; tx_data1 = 8'h5A; req = 2'b10;
    for (int i = 0; i < 3; i++) begin
      watch(8'h00, wc, ic, lc, rs, mb, gs, ds, rx, gb, ok);
      total++; if (!ok || gs !== 2'b10 || ds !== 2'b10 || rx !== 8'h5A)
        begin bad++; $display("FAIL b2b_txn[%0d] ok=%0d gnt=%b done=%b rx=%h want 1/10/10/5a", i, ok, gs, ds, rx); end
      if (i > 0) begin
        total++; if (wc !== 3) begin bad++; $display("FAIL b2b_gap[%0d] got=%0d want=3", i, wc); end
      end
    end
    req = 2'b00;
    repeat (5) @(negedge sys_clk);
  endtask

  task automatic test_miso_pattern();
    int wc, ic, lc, rs; logic [7:0] mb, rx; logic [1:0] gs, ds; logic gb, ok;
    loop_en = 1'b0; tx_data0 = 8'h00; req = 2'b01;
    watch(8'h2A, wc, ic, lc, rs, mb, gs, ds, rx, gb, ok);
    total++; if (!ok || ds !== 2'b01 || rx !== 8'h2A)
      begin bad++; $display("FAIL miso_rx ok=%0d done=%b rx=%h want 1/01/2a", ok, ds, rx); end
    total++; if (mb !== 8'h00 || mosi !== 1'b0)
      begin bad++; $display("FAIL miso_mosi bits=%h mosi=%b want 00/0", mb, mosi); end
    req = 2'b00;
    repeat (5) @(negedge sys_clk);
  endtask

  task automatic test_reset_mid();
    int wc, ic, lc, rs; logic [7:0] mb, rx; logic [1:0] gs, ds; logic gb, ok;
    int  cnt; int guard; logic prev;
    loop_en = 1'b1; tx_data0 = 8'h96; req = 2'b01;
    cnt = 0; guard = 0; prev = 1'b0;
    while (cnt < 4 && guard < 300) begin
      @(negedge sys_clk);
      if (sclk === 1'b1 && prev === 1'b0) cnt++;
      prev = sclk;
      guard++;
    end
    total++; if (cnt !== 4) begin bad++; $display("FAIL mid_reach_edge4 got=%0d want=4", cnt); end
    rstn = 1'b0;
    #1;
    total++; if (cs !== 1'b1 || sclk !== 1'b0 || gnt !== 2'b00 || busy !== 1'b0)
      begin bad++; $display("FAIL mid_async cs=%b sclk=%b gnt=%b busy=%b want 1/0/00/0", cs, sclk, gnt, busy); end
    repeat (2) begin
      @(negedge sys_clk);
      total++; if (done !== 2'b00 || rx_data !== 8'h00)
        begin bad++; $display("FAIL mid_no_done done=%b rx=%h want 00/00", done, rx_data); end
    end
    rstn = 1'b1;
    watch(8'h00, wc, ic, lc, rs, mb, gs, ds, rx, gb, ok);
    total++; if (!ok || lc !== 72 || rs !== 8)
      begin bad++; $display("FAIL mid_fresh ok=%0d low=%0d rises=%0d want 1/72/8", ok, lc, rs); end
    total++; if (ds !== 2'b01 || rx !== 8'h96)
      begin bad++; $display("FAIL mid_fresh_rx done=%b rx=%h want 01/96", ds, rx); end
    req = 2'b00;
    repeat (5) @(negedge sys_clk);
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_both_from_reset();
    test_round_robin();
    test_back_to_back();
    test_miso_pattern();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_rr_master.md
Name: spi_rr_master

Overview:
- Shared SPI master engine with a built-in two-requester round-robin arbiter.
- Two client blocks (e.g. LED-pattern source and config/status poller) share one cs/sclk/mosi/miso bus.
- The block grants one client, runs one full-duplex word transfer to the runner-side slave, returns the received word, then re-arbitrates.

Parameters:
reg_width, 8, bits per SPI transaction (shift register width)
clk_div, 4, sys_clk cycles per sclk half-period (>=1)
cs_gap, 2, minimum sys_clk cycles cs held high between transactions (>=0)

Ports:
sys_clk  input  1  system clock, all logic on rising edge
rstn  input  1  asynchronous active-low reset
req  input  2  per-client request; bit i = client i; hold high until done[i]
tx_data0  input  reg_width  word client 0 sends; sampled at grant
tx_data1  input  reg_width  word client 1 sends; sampled at grant
gnt  output  2  one-hot grant, high for the whole transaction
done  output  2  one-cycle pulse on bit of finishing client
rx_data  output  reg_width  word received in last transaction; valid from done, held until next done
busy  output  1  high from grant until end of cs_gap
cs  output  1  SPI chip select, active low
sclk  output  1  SPI clock, mode 0 (idle low)
mosi  output  1  SPI data out, LSB first
miso  input  1  SPI data in, LSB first

Behaviour:
- Reset (rstn=0, async): cs=1, sclk=0, mosi=0, gnt=0, done=0, busy=0, rx_data=0, state IDLE, rr pointer = "last granted 1" (client 0 wins first tie).
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE:
  - req sampled each cycle; if any bit set, winner chosen (see Arbitration).
  - Next cycle: gnt one-hot set, busy=1, cs=0, winner's tx word latched into shift register, mosi = bit0. Go to SETUP.
- SETUP: clk_div cycles with sclk low, then go to SHIFT.
- SHIFT:
  - sclk toggles every clk_div cycles, giving 2*reg_width edges.
  - Rising edge: miso sampled into rx shift register (LSB first; bit k at k-th rising edge).
  - Falling edge: mosi advances to next tx bit, except after the final falling edge, where mosi holds.
  - After the final falling edge (sclk low), go to HOLD.
- HOLD: clk_div cycles, cs still low, sclk low. Then:
  - cs=1, gnt=0.
  - done[winner]=1 for exactly one cycle; rx_data updated in the same cycle.
  - Go to GAP.
- GAP: cs_gap cycles with cs=1, then busy=0, go to IDLE. When cs_gap=0, go straight to IDLE.
- cs low duration = clk_div*(2*reg_width+2) cycles; defaults give 72. Exactly reg_width rising sclk edges per transaction.
- Arbitration:
  - Only one requester: it wins.
  - Both requesting: the client not granted last time wins.
  - Pointer updates at grant.
- req changes while busy are ignored. A dropped req does not abort the transfer; done still pulses.
- A requester still high after its done is eligible again at the next IDLE.
- tx_data changes after grant have no effect on the current transfer.
- Reset asserted mid-transfer: all outputs return to reset values immediately; no done pulse; partial rx discarded.

Test Plan:
- Loopback, req=01, tx_data0=A5, miso tied to mosi -> gnt=01 one cycle after req:
  - cs low exactly 72 cycles, 8 sclk rising edges, mosi LSB-first 1,0,1,0,0,1,0,1.
  - done=01 one cycle on cs rise; rx_data=A5.
- Both req high from reset, tx_data0=3C, tx_data1=C3, loopback:
  - client 0 served first (rx_data=3C, done[0]), then client 1 (rx_data=C3, done[1]).
  - cs high >=2 cycles between transactions.
- req=11 held for 4 transactions -> grant order 0,1,0,1; gnt never 11; busy low only during IDLE cycles.
- req=10 held for 3 transactions -> client 1 served back-to-back. Each gap has cs high exactly cs_gap+1 cycles; the extra cycle is the IDLE sample.
- miso driven with 8'b00101010 bit-serial on rising sclk, tx_data0=00 -> rx_data=2A at done[0]; mosi constant 0.
- rstn pulsed low at sclk rising edge 4 of a transfer -> cs=1, sclk=0, gnt=00, busy=0 immediately; no done.
  - After release with req=01 still high, a fresh full 72-cycle transaction runs.
